// File: rtl/result_drain.sv
// Result buffer that captures the result-memory write stream and, on start, drains the
// written entries in ascending address order over a valid/ready stream with a running checksum.
module result_drain #(
   parameter int unsigned DW = 8,
   parameter int unsigned AW = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   input  logic              start,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DW-1:0]     out_data,
   output logic [AW-1:0]     out_addr,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [AW:0]       fill_cnt,
   output logic [DW+AW-1:0]  sum_out,
   output logic              wr_err
);

   localparam int unsigned DEPTH = 2 ** AW;
   localparam int unsigned PW    = AW + 1;
   localparam int unsigned SW    = DW + AW;

   typedef enum logic [1:0] {IDLE, SCAN, SEND, DONE} state_t;

   state_t            state;
   logic [DW-1:0]     mem [DEPTH];
   logic [DEPTH-1:0]  mask;
   logic [PW-1:0]     ptr;

   logic              found_c;
   logic [AW-1:0]     idx_c;
   logic              last_c;

   // Lowest written entry at or above ptr, and whether any written entry lies beyond it.
   always_comb begin
      found_c = 1'b0;
      idx_c   = '0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (mask[i] && (PW'(i) >= ptr)) begin
            found_c = 1'b1;
            idx_c   = AW'(i);
         end
      end
      last_c = 1'b1;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (mask[i] && (AW'(i) > idx_c)) begin
            last_c = 1'b0;
         end
      end
   end

   // Buffer data has no reset; it is only meaningful where the mask is set.
   always_ff @(posedge clk) begin
      if (reset && (state == IDLE) && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         mask      <= '0;
         ptr       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         fill_cnt  <= '0;
         sum_out   <= '0;
         wr_err    <= 1'b0;
      end else begin
         if (wr_en && (state != IDLE)) begin
            wr_err <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (wr_en) begin
                  mask[wr_addr] <= 1'b1;
                  if (!mask[wr_addr]) begin
                     fill_cnt <= fill_cnt + PW'(1);
                  end
               end
               if (start) begin
                  state   <= SCAN;
                  ptr     <= '0;
                  sum_out <= '0;
                  busy    <= 1'b1;
               end
            end
            SCAN: begin
               if (found_c) begin
                  out_data  <= mem[idx_c];
                  out_addr  <= idx_c;
                  out_valid <= 1'b1;
                  out_last  <= last_c;
                  ptr       <= PW'(idx_c) + PW'(1);
                  state     <= SEND;
               end else begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            SEND: begin
               // Beat is held until accepted; the checksum only counts transferred words.
               if (out_ready) begin
                  sum_out   <= sum_out + SW'(out_data);
                  out_valid <= 1'b0;
                  if (out_last) begin
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     state <= SCAN;
                  end
               end
            end
            DONE: begin
               done     <= 1'b0;
               mask     <= '0;
               fill_cnt <= '0;
               out_last <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: transaction-level reference model with a per-cycle compare process,
// plus directed scenarios with literal expected beats, sums and timing.
module tb_result_drain;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 2;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          start = 1'b0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_addr;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [AW:0]   fill_cnt;
   logic [DW+AW-1:0] sum_out;
   logic          wr_err;

   result_drain #(.DW(DW), .AW(AW)) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .start(start), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
      .fill_cnt(fill_cnt), .sum_out(sum_out), .wr_err(wr_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
      logic       last;
   } beat_t;

   // Reference model: buffer contents, written set, and the beat list a drain must produce.
   logic [7:0] m_mem [4];
   logic [3:0] m_mask = '0;
   logic [9:0] m_sum = '0;
   bit         m_busy = 0, m_done = 0, m_pend_empty = 0, m_err = 0, hs_edge = 0;
   bit         busy_before, nd;
   beat_t      exp_q[$];
   beat_t      log_q[$];
   beat_t      b;

   always @(posedge clk) begin
      hs_edge = 0;
      if (!reset) begin
         m_mask = '0; m_sum = '0; m_busy = 0; m_done = 0; m_pend_empty = 0; m_err = 0;
         exp_q.delete();
      end else begin
         busy_before = m_busy;
         nd = 0;
         if (wr_en) begin
            if (busy_before) m_err = 1;
            else begin
               m_mem[wr_addr] = wr_data;
               m_mask[wr_addr] = 1'b1;
            end
         end
         if (out_valid && out_ready) begin
            hs_edge = 1;
            log_q.push_back('{addr: out_addr, data: out_data, last: out_last});
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_beat: got addr %0d data 0x%0h, required no beat", out_addr, out_data);
            end else begin
               b = exp_q.pop_front();
               chk("beat_addr", 32'(out_addr), 32'(b.addr));
               chk("beat_data", 32'(out_data), 32'(b.data));
               chk("beat_last", 32'(out_last), 32'(b.last));
               m_sum = m_sum + 10'(b.data);
               if (b.last) nd = 1;
            end
         end
         if (m_done) begin
            m_busy = 0;
            m_mask = '0;
         end else if (!busy_before && start) begin
            m_busy = 1;
            m_sum = '0;
            exp_q.delete();
            for (int i = 0; i < 4; i++)
               if (m_mask[i]) exp_q.push_back('{addr: 2'(i), data: m_mem[i], last: 1'b0});
            if (exp_q.size() == 0) m_pend_empty = 1;
            else exp_q[exp_q.size()-1].last = 1'b1;
         end else if (m_pend_empty) begin
            m_pend_empty = 0;
            nd = 1;
         end
         m_done = nd;
      end
   end

   // Compare process: DUT against the model every cycle, plus beat stability under backpressure.
   bit         armed = 0;
   logic       pv = 1'b0, pl = 1'b0;
   logic [7:0] pd = '0;
   logic [1:0] pa = '0;

   always @(negedge clk) begin
      if (!reset) begin
         pv = 1'b0;
      end else if (armed) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("done", 32'(done), 32'(m_done));
         chk("fill_cnt", 32'(fill_cnt), 32'($countones(m_mask)));
         chk("wr_err", 32'(wr_err), 32'(m_err));
         chk("sum_out", 32'(sum_out), 32'(m_sum));
         chk("valid_when_idle", 32'(out_valid & ~m_busy), 32'(0));
         if (pv && !hs_edge) begin
            chk("hold_valid", 32'(out_valid), 32'(1));
            chk("hold_data", 32'(out_data), 32'(pd));
            chk("hold_addr", 32'(out_addr), 32'(pa));
            chk("hold_last", 32'(out_last), 32'(pl));
         end
         if (done) chk("done_queue_empty", 32'(exp_q.size()), 32'(0));
         pv = out_valid; pd = out_data; pa = out_addr; pl = out_last;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit ok;
      ok = 0;
      for (int i = 0; i < 60; i++) begin
         if (done) begin ok = 1; break; end
         @(negedge clk);
      end
      chk(name, 32'(ok), 32'(1));
      @(negedge clk);
   endtask

   task automatic chk_beat(input string name, input int i, input logic [1:0] a,
                           input logic [7:0] d, input logic l);
      if (log_q.size() > i) begin
         chk({name, "_addr"}, 32'(log_q[i].addr), 32'(a));
         chk({name, "_data"}, 32'(log_q[i].data), 32'(d));
         chk({name, "_last"}, 32'(log_q[i].last), 32'(l));
      end
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_valid"}, 32'(out_valid), 32'(0));
      chk({name, "_data"}, 32'(out_data), 32'(0));
      chk({name, "_addr"}, 32'(out_addr), 32'(0));
      chk({name, "_last"}, 32'(out_last), 32'(0));
      chk({name, "_done"}, 32'(done), 32'(0));
      chk({name, "_busy"}, 32'(busy), 32'(0));
      chk({name, "_fill"}, 32'(fill_cnt), 32'(0));
      chk({name, "_sum"}, 32'(sum_out), 32'(0));
      chk({name, "_err"}, 32'(wr_err), 32'(0));
   endtask

   initial begin
      reset = 1'b0;
      cyc(2);
      reset = 1'b1;
      chk_zero("rst");
      armed = 1;
      out_ready = 1'b1;

      // Full buffer, free-flowing consumer.
      log_q.delete();
      wr(2'd0, 8'h10); wr(2'd1, 8'h20); wr(2'd2, 8'h30); wr(2'd3, 8'hF0);
      chk("t2_fill4", 32'(fill_cnt), 32'(4));
      go();
      chk("t2_scan_novalid", 32'(out_valid), 32'(0));
      chk("t2_scan_busy", 32'(busy), 32'(1));
      @(negedge clk);
      chk("t2_first_valid", 32'(out_valid), 32'(1));
      wait_done("t2_done");
      chk("t2_sum", 32'(sum_out), 32'h150);
      chk("t2_fill0", 32'(fill_cnt), 32'(0));
      chk("t2_idle", 32'(busy), 32'(0));
      chk("t2_nbeats", 32'(log_q.size()), 32'(4));
      chk_beat("t2_b0", 0, 2'd0, 8'h10, 1'b0);
      chk_beat("t2_b1", 1, 2'd1, 8'h20, 1'b0);
      chk_beat("t2_b2", 2, 2'd2, 8'h30, 1'b0);
      chk_beat("t2_b3", 3, 2'd3, 8'hF0, 1'b1);

      // Sparse buffer.
      log_q.delete();
      wr(2'd1, 8'h7F); wr(2'd3, 8'h01);
      go();
      wait_done("t3_done");
      chk("t3_sum", 32'(sum_out), 32'h080);
      chk("t3_nbeats", 32'(log_q.size()), 32'(2));
      chk_beat("t3_b0", 0, 2'd1, 8'h7F, 1'b0);
      chk_beat("t3_b1", 1, 2'd3, 8'h01, 1'b1);

      // Empty buffer: two busy cycles, done in the second, no beats.
      log_q.delete();
      go();
      chk("t4_k_busy", 32'(busy), 32'(1));
      chk("t4_k_done", 32'(done), 32'(0));
      @(negedge clk);
      chk("t4_k1_busy", 32'(busy), 32'(1));
      chk("t4_k1_done", 32'(done), 32'(1));
      @(negedge clk);
      chk("t4_k2_busy", 32'(busy), 32'(0));
      chk("t4_k2_done", 32'(done), 32'(0));
      chk("t4_nbeats", 32'(log_q.size()), 32'(0));
      chk("t4_sum", 32'(sum_out), 32'(0));

      // Backpressure with start and write attempts mid-drain.
      log_q.delete();
      out_ready = 1'b0;
      wr(2'd0, 8'hA1); wr(2'd2, 8'hB2);
      go();
      @(negedge clk);
      chk("t5_valid", 32'(out_valid), 32'(1));
      start = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'hEE;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      cyc(4);
      chk("t5_hold_valid", 32'(out_valid), 32'(1));
      chk("t5_hold_addr", 32'(out_addr), 32'(0));
      chk("t5_hold_data", 32'(out_data), 32'hA1);
      chk("t5_wr_err", 32'(wr_err), 32'(1));
      chk("t5_fill", 32'(fill_cnt), 32'(2));
      out_ready = 1'b1;
      wait_done("t5_done");
      chk("t5_sum", 32'(sum_out), 32'h153);
      chk("t5_nbeats", 32'(log_q.size()), 32'(2));
      chk_beat("t5_b0", 0, 2'd0, 8'hA1, 1'b0);
      chk_beat("t5_b1", 1, 2'd2, 8'hB2, 1'b1);
      cyc(2);
      chk("t5_no_restart", 32'(busy), 32'(0));

      // Same-edge write and start, then overwrite of one address.
      log_q.delete();
      wr_en = 1'b1; wr_addr = 2'd2; wr_data = 8'h55; start = 1'b1;
      @(negedge clk);
      wr_en = 1'b0; start = 1'b0;
      wait_done("t6a_done");
      chk("t6a_nbeats", 32'(log_q.size()), 32'(1));
      chk_beat("t6a_b0", 0, 2'd2, 8'h55, 1'b1);
      chk("t6a_sum", 32'(sum_out), 32'h055);
      log_q.delete();
      wr(2'd0, 8'h11); wr(2'd0, 8'h22);
      chk("t6b_fill1", 32'(fill_cnt), 32'(1));
      go();
      wait_done("t6b_done");
      chk("t6b_nbeats", 32'(log_q.size()), 32'(1));
      chk_beat("t6b_b0", 0, 2'd0, 8'h22, 1'b1);
      chk("t6b_sum", 32'(sum_out), 32'h022);

      // Reset in the middle of a drain aborts it with no done pulse.
      out_ready = 1'b0;
      wr(2'd1, 8'h33); wr(2'd2, 8'h44);
      go();
      @(negedge clk);
      chk("t1_mid_valid", 32'(out_valid), 32'(1));
      reset = 1'b0;
      @(negedge clk);
      chk_zero("t1_mid_rst");
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_no_done", 32'(done), 32'(0));
         chk("t1_no_busy", 32'(busy), 32'(0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
